// File: rtl/bmm150_pkg.sv
// Shared register map, opcode helpers and state/error encodings for the BMM150 sequencer.
package bmm150_pkg;

    localparam logic [7:0] REG_CHIP_ID    = 8'h40;
    localparam logic [7:0] REG_DATA_X_LSB = 8'h42;
    localparam logic [7:0] REG_PWR_CTRL   = 8'h4B;
    localparam logic [7:0] REG_OP_MODE    = 8'h4C;
    localparam logic [7:0] READ_BIT       = 8'h80;
    localparam logic [7:0] PWR_CTRL_ON    = 8'h01;

    localparam logic [1:0] OPMODE_NORMAL  = 2'b00;
    localparam logic [1:0] OPMODE_SLEEP   = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWR_ON,
        ST_PWR_WAIT,
        ST_READ_ID,
        ST_CHECK_ID,
        ST_SET_MODE,
        ST_BURST,
        ST_PUBLISH,
        ST_WAIT_PERIOD,
        ST_ERROR
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'b00,
        ERR_ID_MISMATCH = 2'b01,
        ERR_TIMEOUT     = 2'b10
    } err_code_t;

    // OP_MODE register layout: [5:3] data rate, [2:1] operation mode.
    function automatic logic [7:0] opmode_byte(input logic [2:0] odr, input logic [1:0] mode);
        return {2'b00, odr, mode, 1'b0};
    endfunction

endpackage

// File: rtl/bmm150_spi_req.sv
// Single-transaction front end for spi_master_bmm150: busy-gated start pulse,
// held command fields, done wait with timeout, and a one-cycle ack to the sequencer.
module bmm150_spi_req #(
    parameter int unsigned XACT_TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    input  logic       rw_i,
    output logic       ack_o,
    output logic [7:0] rdata_o,
    output logic       timeout_o,
    output logic       spi_start_o,
    output logic [7:0] spi_reg_addr_o,
    output logic [7:0] spi_tx_data_o,
    output logic       spi_rw_o,
    input  logic [7:0] spi_rx_data_i,
    input  logic       spi_busy_i,
    input  logic       spi_done_i
);

    typedef enum logic {REQ_IDLE, REQ_WAIT} req_state_t;

    localparam logic [31:0] TMO_LAST = 32'(XACT_TIMEOUT_CYCLES - 1);

    req_state_t  state_q, state_d;
    logic        start_q, start_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rw_q, rw_d;
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        cnt_d     = cnt_q;
        ack_o     = 1'b0;
        timeout_o = 1'b0;
        rdata_o   = spi_rx_data_i;
        case (state_q)
            REQ_IDLE: begin
                if (req_i && !spi_busy_i) begin
                    start_d = 1'b1;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    rw_d    = rw_i;
                    cnt_d   = '0;
                    state_d = REQ_WAIT;
                end
            end
            REQ_WAIT: begin
                // cnt_q equals cycles elapsed since the start pulse was on the wire
                if (spi_done_i) begin
                    ack_o   = 1'b1;
                    state_d = REQ_IDLE;
                end else if (cnt_q >= TMO_LAST) begin
                    timeout_o = 1'b1;
                    state_d   = REQ_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = REQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= REQ_IDLE;
            start_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            cnt_q   <= cnt_d;
        end
    end

    assign spi_start_o    = start_q;
    assign spi_reg_addr_o = addr_q;
    assign spi_tx_data_o  = wdata_q;
    assign spi_rw_o       = rw_q;

endmodule

// File: rtl/bmm150_ctrl.sv
// BMM150 power-up / ID check / mode setup sequencer with periodic data-register bursts.
// Optional BMM150_DRDY_CHECK_EN gates publishing on the data-ready bit and adds drdy_miss_cnt.
module bmm150_ctrl
    import bmm150_pkg::*;
#(
    parameter int unsigned POWERUP_WAIT_CYCLES  = 100000,
    parameter int unsigned SAMPLE_PERIOD_CYCLES = 1000000,
    parameter int unsigned XACT_TIMEOUT_CYCLES  = 4096,
    parameter logic [7:0]  CHIP_ID_EXP          = 8'h32,
    parameter logic [2:0]  ODR_CODE             = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        spi_start,
    output logic [7:0]  spi_reg_addr,
    output logic [7:0]  spi_tx_data,
    output logic        spi_rw,
    input  logic [7:0]  spi_rx_data,
    input  logic        spi_busy,
    input  logic        spi_done,
    output logic [12:0] mag_x,
    output logic [12:0] mag_y,
    output logic [14:0] mag_z,
    output logic [13:0] rhall,
    output logic        data_valid,
    output logic        init_done,
    output logic        err,
    output logic [1:0]  err_code
`ifdef BMM150_DRDY_CHECK_EN
    ,
    output logic [15:0] drdy_miss_cnt
`endif
);

    localparam logic [31:0] PWR_LAST   = 32'(POWERUP_WAIT_CYCLES - 1);
    // Period counter restarts on the burst's first start pulse; the request path adds two cycles.
    localparam logic [31:0] PER_THRESH = (SAMPLE_PERIOD_CYCLES >= 2) ? 32'(SAMPLE_PERIOD_CYCLES - 2) : '0;

    ctrl_state_t state_q, state_d;
    err_code_t   err_q, err_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] per_cnt_q, per_cnt_d;
    logic [7:0]  id_q, id_d;
    logic [7:0]  bytes_q [8];
    logic [7:0]  bytes_d [8];
    logic [12:0] mag_x_q, mag_x_d, mag_y_q, mag_y_d;
    logic [14:0] mag_z_q, mag_z_d;
    logic [13:0] rhall_q, rhall_d;
    logic        dv_q, dv_d;
    logic        init_q, init_d;
    logic        pub;

    logic        req, ack, tmo;
    logic [7:0]  req_addr, req_wdata, rdata;
    logic        req_rw;

`ifdef BMM150_DRDY_CHECK_EN
    logic [15:0] miss_q, miss_d;
    assign pub = (state_q == ST_PUBLISH) && bytes_q[6][0];
`else
    assign pub = (state_q == ST_PUBLISH);
`endif

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        idx_d      = idx_q;
        wait_cnt_d = wait_cnt_q;
        id_d       = id_q;
        bytes_d    = bytes_q;
        init_d     = init_q;
        req        = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_rw     = 1'b0;
        per_cnt_d  = (per_cnt_q != '1) ? per_cnt_q + 32'd1 : per_cnt_q;
        if (state_q == ST_BURST && idx_q == 3'd0 && spi_start) per_cnt_d = 32'd1;

        case (state_q)
            ST_IDLE: begin
                init_d = 1'b0;
                if (enable && !spi_busy) state_d = ST_PWR_ON;
            end
            ST_PWR_ON: begin
                req       = 1'b1;
                req_addr  = REG_PWR_CTRL;
                req_wdata = PWR_CTRL_ON;
                if (ack) begin
                    wait_cnt_d = '0;
                    state_d    = ST_PWR_WAIT;
                end
            end
            ST_PWR_WAIT: begin
                if (wait_cnt_q >= PWR_LAST) state_d = ST_READ_ID;
                else wait_cnt_d = wait_cnt_q + 32'd1;
            end
            ST_READ_ID: begin
                req      = 1'b1;
                req_addr = READ_BIT | REG_CHIP_ID;
                req_rw   = 1'b1;
                if (ack) begin
                    id_d    = rdata;
                    state_d = ST_CHECK_ID;
                end
            end
            ST_CHECK_ID: begin
                if (id_q == CHIP_ID_EXP) state_d = ST_SET_MODE;
                else begin
                    err_d   = ERR_ID_MISMATCH;
                    state_d = ST_ERROR;
                end
            end
            ST_SET_MODE: begin
                req       = 1'b1;
                req_addr  = REG_OP_MODE;
                req_wdata = opmode_byte(ODR_CODE, OPMODE_NORMAL);
                if (ack) begin
                    init_d  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                req      = 1'b1;
                req_addr = READ_BIT | (REG_DATA_X_LSB + {5'b00000, idx_q});
                req_rw   = 1'b1;
                if (ack) begin
                    bytes_d[idx_q] = rdata;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = ST_PUBLISH;
                end
            end
            ST_PUBLISH: state_d = ST_WAIT_PERIOD;
            ST_WAIT_PERIOD: begin
                if (!enable) begin
                    init_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (per_cnt_q >= PER_THRESH) begin
                    idx_d   = '0;
                    state_d = ST_BURST;
                end
            end
            ST_ERROR: ;
            default: state_d = ST_ERROR;
        endcase

        if (tmo) begin
            err_d   = ERR_TIMEOUT;
            state_d = ST_ERROR;
        end
    end

    always_comb begin
        mag_x_d = mag_x_q;
        mag_y_d = mag_y_q;
        mag_z_d = mag_z_q;
        rhall_d = rhall_q;
        dv_d    = pub;
        if (pub) begin
            mag_x_d = {bytes_q[1], bytes_q[0][7:3]};
            mag_y_d = {bytes_q[3], bytes_q[2][7:3]};
            mag_z_d = {bytes_q[5], bytes_q[4][7:1]};
            rhall_d = {bytes_q[7], bytes_q[6][7:2]};
        end
`ifdef BMM150_DRDY_CHECK_EN
        miss_d = miss_q;
        if (state_q == ST_PUBLISH && !bytes_q[6][0] && miss_q != '1) miss_d = miss_q + 16'd1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            err_q      <= ERR_NONE;
            idx_q      <= '0;
            wait_cnt_q <= '0;
            per_cnt_q  <= '0;
            id_q       <= '0;
            for (int unsigned i = 0; i < 8; i++) bytes_q[i] <= '0;
            init_q     <= 1'b0;
            mag_x_q    <= '0;
            mag_y_q    <= '0;
            mag_z_q    <= '0;
            rhall_q    <= '0;
            dv_q       <= 1'b0;
`ifdef BMM150_DRDY_CHECK_EN
            miss_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            wait_cnt_q <= wait_cnt_d;
            per_cnt_q  <= per_cnt_d;
            id_q       <= id_d;
            bytes_q    <= bytes_d;
            init_q     <= init_d;
            mag_x_q    <= mag_x_d;
            mag_y_q    <= mag_y_d;
            mag_z_q    <= mag_z_d;
            rhall_q    <= rhall_d;
            dv_q       <= dv_d;
`ifdef BMM150_DRDY_CHECK_EN
            miss_q     <= miss_d;
`endif
        end
    end

    bmm150_spi_req #(
        .XACT_TIMEOUT_CYCLES(XACT_TIMEOUT_CYCLES)
    ) u_req (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req),
        .addr_i        (req_addr),
        .wdata_i       (req_wdata),
        .rw_i          (req_rw),
        .ack_o         (ack),
        .rdata_o       (rdata),
        .timeout_o     (tmo),
        .spi_start_o   (spi_start),
        .spi_reg_addr_o(spi_reg_addr),
        .spi_tx_data_o (spi_tx_data),
        .spi_rw_o      (spi_rw),
        .spi_rx_data_i (spi_rx_data),
        .spi_busy_i    (spi_busy),
        .spi_done_i    (spi_done)
    );

    logic unused_bits;
    assign unused_bits = ^{bytes_q[0][2:0], bytes_q[2][2:0], bytes_q[4][0], bytes_q[6][1:0]};

    assign mag_x      = mag_x_q;
    assign mag_y      = mag_y_q;
    assign mag_z      = mag_z_q;
    assign rhall      = rhall_q;
    assign data_valid = dv_q;
    assign init_done  = init_q;
    assign err        = (err_q != ERR_NONE);
    assign err_code   = err_q;
`ifdef BMM150_DRDY_CHECK_EN
    assign drdy_miss_cnt = miss_q;
`endif

endmodule
